// File: rtl/jt10_adpcm_pkg.sv
// Shared constants and per-channel state encoding for the ADPCM-A scheduler.
package jt10_adpcm_pkg;
  localparam int unsigned CHN = 6;
  localparam int unsigned AW  = 24;
  localparam int unsigned RW  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_PLAY = 2'd2
  } chst_e;
endpackage

// File: rtl/jt10_adpcm_chctl.sv
// One ADPCM-A channel: key pending bits, start/end registers, nibble counter and play FSM.
module jt10_adpcm_chctl
  import jt10_adpcm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          visit_i,
  input  logic          keyon_i,
  input  logic          keyoff_i,
  input  logic          wr_start_i,
  input  logic          wr_end_i,
  input  logic [RW-1:0] wr_data_i,
  input  logic          flag_clr_i,
  output logic          rd_o,
  output logic          clr_o,
  output logic [AW-1:0] addr_o,
  output logic          nib_o,
  output logic          busy_o,
  output logic          flag_o
);
  chst_e         state_q, state_d;
  logic          on_q, on_d, off_q, off_d;
  logic [RW-1:0] start_q, end_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          flag_q, flag_d, flag_set;
  logic          on_eff, off_eff;

  always_comb begin
    // pulses arriving on the visit cycle itself are honoured, not lost
    on_eff   = on_q | keyon_i;
    off_eff  = off_q | keyoff_i;
    state_d  = state_q;
    on_d     = on_eff;
    off_d    = off_eff;
    cnt_d    = cnt_q;
    flag_set = 1'b0;
    rd_o     = 1'b0;
    clr_o    = 1'b0;
    if (visit_i) begin
      on_d  = 1'b0;
      off_d = 1'b0;
      case (state_q)
        ST_IDLE: if (on_eff && !off_eff) state_d = ST_INIT;
        ST_INIT: begin
          if (off_eff) state_d = ST_IDLE;
          else begin
            clr_o   = 1'b1;
            cnt_d   = {start_q, 8'h00, 1'b0};
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (off_eff)     state_d = ST_IDLE;
          else if (on_eff) state_d = ST_INIT;
          else begin
            rd_o  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {end_q, 8'hFF, 1'b1}) begin
              state_d  = ST_IDLE;
              flag_set = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    flag_d = (flag_q & ~flag_clr_i) | flag_set;
    addr_o = rd_o ? cnt_q[AW:1] : '0;
    nib_o  = rd_o & cnt_q[0];
    busy_o = (state_q != ST_IDLE);
    flag_o = flag_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      on_q    <= 1'b0;
      off_q   <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      if (wr_start_i) start_q <= wr_data_i;
      if (wr_end_i)   end_q   <= wr_data_i;
    end
  end
endmodule

// File: rtl/jt10_adpcm_sched.sv
// ADPCM-A slot scheduler: rotating channel index, half-rate enable and per-slot fetch outputs.
module jt10_adpcm_sched
  import jt10_adpcm_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic [CHN-1:0] keyon,
  input  logic [CHN-1:0] keyoff,
  input  logic           wr,
  input  logic [2:0]     wr_ch,
  input  logic           wr_end,
  input  logic [RW-1:0]  wr_data,
  input  logic [CHN-1:0] flag_clr,
  output logic [2:0]     ch,
  output logic           cen55,
  output logic [AW-1:0]  addr,
  output logic           nibble,
  output logic           rd,
  output logic           clr,
  output logic [CHN-1:0] busy,
  output logic [CHN-1:0] flags
);
  logic [2:0]    ch_q;
  logic          phase_q;
  logic [AW-1:0] addr_q;
  logic          nib_q, rd_q, clr_q;

  logic [CHN-1:0] v_rd, v_clr, v_nib;
  logic [AW-1:0]  v_addr [CHN];
  logic [AW-1:0]  sel_addr;
  logic           sel_nib, sel_rd, sel_clr;

  for (genvar k = 0; k < CHN; k++) begin : g_ch
    jt10_adpcm_chctl u_chctl (
      .clk        (clk),
      .rst_n      (rst_n),
      .visit_i    (cen && (ch_q == 3'(k))),
      .keyon_i    (keyon[k]),
      .keyoff_i   (keyoff[k]),
      .wr_start_i (wr && !wr_end && (wr_ch == 3'(k))),
      .wr_end_i   (wr && wr_end && (wr_ch == 3'(k))),
      .wr_data_i  (wr_data),
      .flag_clr_i (flag_clr[k]),
      .rd_o       (v_rd[k]),
      .clr_o      (v_clr[k]),
      .addr_o     (v_addr[k]),
      .nib_o      (v_nib[k]),
      .busy_o     (busy[k]),
      .flag_o     (flags[k])
    );
  end

  always_comb begin
    sel_addr = '0;
    sel_nib  = 1'b0;
    sel_rd   = 1'b0;
    sel_clr  = 1'b0;
    for (int unsigned i = 0; i < CHN; i++) begin
      if (ch_q == 3'(i)) begin
        sel_addr = v_addr[i];
        sel_nib  = v_nib[i];
        sel_rd   = v_rd[i];
        sel_clr  = v_clr[i];
      end
    end
  end

  // the visited slot's result is presented while the next slot index is shown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q    <= '0;
      phase_q <= 1'b0;
      addr_q  <= '0;
      nib_q   <= 1'b0;
      rd_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else if (cen) begin
      ch_q    <= (ch_q == 3'(CHN-1)) ? '0 : ch_q + 3'd1;
      if (ch_q == 3'(CHN-1)) phase_q <= ~phase_q;
      addr_q  <= sel_addr;
      nib_q   <= sel_nib;
      rd_q    <= sel_rd;
      clr_q   <= sel_clr;
    end
  end

  assign ch     = ch_q;
  assign cen55  = cen & phase_q;
  assign addr   = addr_q;
  assign nibble = nib_q;
  assign rd     = rd_q;
  assign clr    = clr_q;
endmodule

// File: tb/tb_jt10_adpcm_sched.sv
// Self-checking bench for jt10_adpcm_sched against a behavioural slot/playback model.
module tb_jt10_adpcm_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [5:0]  keyon = '0, keyoff = '0, flag_clr = '0;
  logic        wr = 1'b0, wr_end = 1'b0;
  logic [2:0]  wr_ch = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  ch;
  logic        cen55, nibble, rd, clr;
  logic [23:0] addr;
  logic [5:0]  busy, flags;

  jt10_adpcm_sched dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .keyon(keyon), .keyoff(keyoff),
    .wr(wr), .wr_ch(wr_ch), .wr_end(wr_end), .wr_data(wr_data), .flag_clr(flag_clr),
    .ch(ch), .cen55(cen55), .addr(addr), .nibble(nibble), .rd(rd), .clr(clr),
    .busy(busy), .flags(flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 = silent, 1 = armed (restart pending at next visit), 2 = playing
  int          m_mode [6];
  bit          m_on [6], m_off [6], m_flag [6];
  int unsigned m_start [6], m_end [6];
  longint      m_pos [6];          // current nibble index = byte*2 + nibble
  int          m_ch;
  bit          m_phase;
  longint      e_addr;
  bit          e_nib, e_rd, e_clr;

  function automatic longint last_nib(input int k);
    return 2 * (longint'(m_end[k]) * 256 + 255) + 1;
  endfunction

  function automatic bit end_event_now(input int k);
    return cen && rst_n && m_ch == k && m_mode[k] == 2 && !(m_on[k] | keyon[k])
           && !(m_off[k] | keyoff[k]) && m_pos[k] == last_nib(k);
  endfunction

  task automatic model_step();
    bit [5:0] set_mask;
    int k;
    bit on, off;
    if (!rst_n) begin
      for (int n = 0; n < 6; n++) begin
        m_mode[n] = 0; m_on[n] = 0; m_off[n] = 0; m_flag[n] = 0;
        m_start[n] = 0; m_end[n] = 0; m_pos[n] = 0;
      end
      m_ch = 0; m_phase = 0; e_addr = 0; e_nib = 0; e_rd = 0; e_clr = 0;
      return;
    end
    set_mask = '0;
    for (int n = 0; n < 6; n++) begin
      m_on[n]  = m_on[n] | keyon[n];
      m_off[n] = m_off[n] | keyoff[n];
    end
    if (cen) begin
      k = m_ch;
      e_addr = 0; e_nib = 0; e_rd = 0; e_clr = 0;
      on = m_on[k]; off = m_off[k];
      m_on[k] = 0; m_off[k] = 0;
      if (m_mode[k] == 0) begin
        if (on && !off) m_mode[k] = 1;
      end else if (m_mode[k] == 1) begin
        if (off) m_mode[k] = 0;
        else begin
          e_clr = 1;
          m_pos[k] = longint'(m_start[k]) * 512;
          m_mode[k] = 2;
        end
      end else begin
        if (off) m_mode[k] = 0;
        else if (on) m_mode[k] = 1;
        else begin
          e_rd = 1;
          e_addr = m_pos[k] / 2;
          e_nib = bit'(m_pos[k] % 2);
          if (m_pos[k] == last_nib(k)) begin
            m_mode[k] = 0;
            set_mask[k] = 1;
          end
          m_pos[k] = (m_pos[k] + 1) % (longint'(1) << 25);
        end
      end
      if (m_ch == 5) begin m_ch = 0; m_phase = !m_phase; end
      else m_ch = m_ch + 1;
    end
    for (int n = 0; n < 6; n++) m_flag[n] = set_mask[n] | (m_flag[n] & !flag_clr[n]);
    if (wr && wr_ch < 6) begin
      if (wr_end) m_end[wr_ch] = wr_data;
      else        m_start[wr_ch] = wr_data;
    end
  endtask

  task automatic check_all();
    bit [5:0] eb, ef;
    for (int n = 0; n < 6; n++) begin
      eb[n] = (m_mode[n] != 0);
      ef[n] = m_flag[n];
    end
    chk("ch", ch, m_ch);
    chk("cen55", cen55, cen & m_phase);
    chk("addr", addr, e_addr);
    chk("nibble", nibble, e_nib);
    chk("rd", rd, e_rd);
    chk("clr", clr, e_clr);
    chk("busy", busy, eb);
    chk("flags", flags, ef);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    keyon = '0; keyoff = '0; wr = 0; flag_clr = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_reg(input int c, input bit e, input int d);
    wr = 1; wr_ch = 3'(c); wr_end = e; wr_data = 16'(d);
    tick();
  endtask

  task automatic wait_ch(input int target);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ch == 3'(target)) ok = 1;
      else tick();
    end
    if (!ok) chk("wait_ch_timeout", 0, 1);
  endtask

  typedef struct { bit cen; int ch; bit c55; } vec_t;
  vec_t tbl [12];

  initial begin
    int cnt, first_addr, last_addr, last_nib_v;
    bit done;

    // after reset + constant cen: two rounds, second with cen55 high
    for (int i = 0; i < 12; i++) begin
      tbl[i].cen = 1;
      tbl[i].ch  = (i + 1) % 6;
      tbl[i].c55 = (i >= 5 && i <= 10);
    end

    rst_n = 0; cen = 1;
    tick();
    chk("rst_ch", ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", flags, 0);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      cen = tbl[i].cen;
      tick();
      chk("tbl_ch", ch, tbl[i].ch);
      chk("tbl_cen55", cen55, tbl[i].c55);
      chk("tbl_rd", rd, 0);
    end

    // full sample on channel 2: 0x000100 .. 0x0001FF
    wr_reg(2, 0, 16'h0001);
    wr_reg(2, 1, 16'h0001);
    keyon[2] = 1;
    cnt = 0; first_addr = -1; last_addr = -1; last_nib_v = -1; done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      tick();
      if (rd && ch == 3) begin
        if (cnt == 0) begin
          first_addr = int'(addr);
          chk("first_nib", nibble, 0);
        end
        cnt++; last_addr = int'(addr); last_nib_v = nibble;
      end
      if (cnt > 0 && !busy[2]) done = 1;
    end
    if (!done) chk("ch2_play_timeout", 0, 1);
    chk("ch2_nibbles", cnt, 512);
    chk("ch2_first_addr", first_addr, 'h100);
    chk("ch2_last_addr", last_addr, 'h1FF);
    chk("ch2_last_nib", last_nib_v, 1);
    chk("ch2_busy_end", busy[2], 0);
    chk("ch2_flag_end", flags[2], 1);

    // key-off mid-play on channel 0
    wr_reg(0, 0, 5);
    wr_reg(0, 1, 5);
    keyon[0] = 1;
    run(40);
    chk("ch0_playing", busy[0], 1);
    keyoff[0] = 1;
    run(7);
    chk("ch0_keyoff_busy", busy[0], 0);
    chk("ch0_keyoff_flag", flags[0], 0);

    // simultaneous / separate keyon+keyoff on an idle channel
    wait_ch(5);
    keyon[4] = 1; keyoff[4] = 1;
    run(12);
    chk("ch4_same_cycle", busy[4], 0);
    wait_ch(5);
    keyon[4] = 1; tick();
    keyoff[4] = 1; tick();
    run(10);
    chk("ch4_sep_cycles", busy[4], 0);

    // alternating cen during playback of channel 1
    wr_reg(1, 0, 2);
    wr_reg(1, 1, 2);
    keyon[1] = 1;
    for (int i = 0; i < 200; i++) begin
      cen = (i % 2 == 0);
      tick();
    end
    cen = 1;
    chk("ch1_gated_playing", busy[1], 1);
    keyoff[1] = 1;
    run(8);
    chk("ch1_gated_off", busy[1], 0);

    // flag_clr coincident with a new end event on channel 2: set wins
    keyon[2] = 1;
    done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (end_event_now(2)) begin
        flag_clr[2] = 1;
        done = 1;
      end
      tick();
    end
    if (!done) chk("ch2_replay_timeout", 0, 1);
    chk("flag_set_wins", flags[2], 1);
    flag_clr[2] = 1;
    tick();
    chk("flag_lone_clr", flags[2], 0);

    // reset while three channels play
    keyon = 6'b001011;
    run(30);
    chk("three_busy", busy, 6'b001011);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midplay_rst_busy", busy, 0);
    chk("midplay_rst_flags", flags, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cen = ($urandom % 4) != 0;
      if ($urandom % 25 == 0) keyon[$urandom % 6] = 1;
      if ($urandom % 60 == 0) keyoff[$urandom % 6] = 1;
      if ($urandom % 15 == 0) begin
        wr = 1; wr_ch = 3'($urandom % 8); wr_end = 1'($urandom % 2);
        wr_data = 16'($urandom % 3);
      end
      if ($urandom % 40 == 0) flag_clr = 6'($urandom);
      rst_n = !(i == 1500);
      tick();
    end
    rst_n = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
